// File: rtl/spi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// spi_tx_arbiter
//
// Purpose:
//   Shares the single outbound SPI transmit byte channel between the
//   response sources: error table (0), status register (1), memory byte
//   stream (2) and image-count register (3). Whole bursts (terminated by
//   req_last) are granted in round-robin order. One registered byte stage
//   drives the SPI transmit path.
//
// Optional feature (compile-time macro SPI_TX_STALL_TIMEOUT_EN):
//   When defined, a burst whose owner stops presenting bytes for
//   TIMEOUT_CYCLES consecutive cycles is aborted and timeout_flag pulses.
//   When undefined, timeout_flag is tied low and a stalled burst keeps the
//   grant indefinitely.
//
// Parameters:
//   NUM_REQ         number of requesters (2..8)
//   SRC_W           width of requester index (clog2(NUM_REQ))
//   TIMEOUT_CYCLES  idle cycles tolerated mid-burst (1..65535)
//
// Ports:
//   sysClk        in   system clock, rising edge
//   sysRst_n      in   asynchronous active-low reset
//   req_byte      in   byte of requester i in bits [8i+7:8i]
//   req_valid     in   requester i presents a byte
//   req_last      in   presented byte ends the burst
//   req_ready     out  byte of requester i accepted (with req_valid[i])
//   tx_byte       out  byte toward the SPI transmit path
//   tx_valid      out  tx_byte is valid
//   tx_last       out  tx_byte is the last byte of its burst
//   tx_src        out  requester index that produced tx_byte
//   tx_ready      in   SPI path consumes tx_byte this cycle
//   busy          out  a burst is currently granted
//   timeout_flag  out  one-cycle pulse on burst abort
// ---------------------------------------------------------------------------
module spi_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int SRC_W          = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   sysClk,
   input  logic                   sysRst_n,
   input  logic [NUM_REQ*8-1:0]   req_byte,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_byte,
   output logic                   tx_valid,
   output logic                   tx_last,
   output logic [SRC_W-1:0]       tx_src,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic                   timeout_flag
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [SRC_W-1:0] grant_reg, grant_next;
   logic [SRC_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [SRC_W-1:0] grant_inc;

   logic [7:0]       byte_arr [NUM_REQ];
   logic             stage_free;
   logic             g_valid;
   logic             g_last;
   logic             xfer;
   logic             scan_hit;
   logic [SRC_W-1:0] scan_idx;

   // Elaboration-time sanity check of the parameter set.
   generate
      if (((2 ** SRC_W) < NUM_REQ) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_cfg
         $error("spi_tx_arbiter: inconsistent NUM_REQ/SRC_W/TIMEOUT_CYCLES");
      end
   endgenerate

   // Unpack the flat byte bus so the granted byte can be picked by index.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign byte_arr[gi] = req_byte[8*gi +: 8];
      end
   endgenerate

   // The output stage can take a byte when empty or being drained now.
   assign stage_free = !tx_valid || tx_ready;
   assign busy       = (state_reg == BURST);
   assign g_valid    = req_valid[grant_reg];
   assign g_last     = req_last[grant_reg];
   assign xfer       = busy && g_valid && stage_free;
   assign grant_inc  = (grant_reg == SRC_W'(NUM_REQ - 1)) ? '0 : grant_reg + SRC_W'(1);

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = busy && (grant_reg == SRC_W'(gi)) && stage_free;
      end
   endgenerate

   // Round-robin scan starting at rr_ptr. Iterating from the farthest
   // offset down lets the nearest asserted requester win.
   always_comb begin
      int idx;
      scan_hit = 1'b0;
      scan_idx = '0;
      idx      = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr_reg) + i) % NUM_REQ;
         if (req_valid[idx[SRC_W-1:0]]) begin
            scan_hit = 1'b1;
            scan_idx = idx[SRC_W-1:0];
         end
      end
   end

`ifdef SPI_TX_STALL_TIMEOUT_EN
   logic [15:0] stall_reg, stall_next;
   logic        timeout_next;
   logic        timeout_reg;
`endif

   // Next-state logic
   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      rr_ptr_next = rr_ptr_reg;
`ifdef SPI_TX_STALL_TIMEOUT_EN
      stall_next   = stall_reg;
      timeout_next = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (scan_hit) begin
               state_next = BURST;
               grant_next = scan_idx;
`ifdef SPI_TX_STALL_TIMEOUT_EN
               stall_next = '0;
`endif
            end
         end
         BURST: begin
            if (xfer) begin
`ifdef SPI_TX_STALL_TIMEOUT_EN
               stall_next = '0;
`endif
               if (g_last) begin
                  state_next  = IDLE;
                  rr_ptr_next = grant_inc;
               end
            end
`ifdef SPI_TX_STALL_TIMEOUT_EN
            // Only an absent byte counts; a present byte blocked by
            // backpressure leaves the counter untouched.
            else if (!g_valid) begin
               if (stall_reg == 16'(TIMEOUT_CYCLES - 1)) begin
                  stall_next   = '0;
                  timeout_next = 1'b1;
                  state_next   = IDLE;
                  rr_ptr_next  = grant_inc;
               end else begin
                  stall_next = stall_reg + 16'd1;
               end
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         state_reg  <= IDLE;
         grant_reg  <= '0;
         rr_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

`ifdef SPI_TX_STALL_TIMEOUT_EN
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         stall_reg   <= '0;
         timeout_reg <= 1'b0;
      end else begin
         stall_reg   <= stall_next;
         timeout_reg <= timeout_next;
      end
   end
   assign timeout_flag = timeout_reg;
`else
   assign timeout_flag = 1'b0;
`endif

   // Output byte stage: a load always wins over a drain, which keeps
   // tx_valid high on a simultaneous consume/load for full throughput.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         tx_valid <= 1'b0;
         tx_byte  <= '0;
         tx_last  <= 1'b0;
         tx_src   <= '0;
      end else if (xfer) begin
         tx_valid <= 1'b1;
         tx_byte  <= byte_arr[grant_reg];
         tx_last  <= g_last;
         tx_src   <= grant_reg;
      end else if (tx_ready) begin
         tx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_tx_arbiter
//
// Purpose: self-checking bench for spi_tx_arbiter. Requesters are driven
// from per-source burst lists; the expected output byte stream is derived
// from a round-robin reference over whole bursts. Directed steps cover
// latency, round-robin order, backpressure, mid-burst reset and the
// stall-timeout behaviour (with or without SPI_TX_STALL_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_spi_tx_arbiter;

   localparam int N = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [N*8-1:0]  req_byte = '0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_last = '0;
   logic [N-1:0]    req_ready;
   logic [7:0]      tx_byte;
   logic            tx_valid;
   logic            tx_last;
   logic [SW-1:0]   tx_src;
   logic            tx_ready = 1'b0;
   logic            busy;
   logic            timeout_flag;

   always #5 clk = ~clk;

   spi_tx_arbiter #(
      .NUM_REQ(N),
      .SRC_W(SW),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .sysClk(clk),
      .sysRst_n(rst_n),
      .req_byte(req_byte),
      .req_valid(req_valid),
      .req_last(req_last),
      .req_ready(req_ready),
      .tx_byte(tx_byte),
      .tx_valid(tx_valid),
      .tx_last(tx_last),
      .tx_src(tx_src),
      .tx_ready(tx_ready),
      .busy(busy),
      .timeout_flag(timeout_flag)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Traffic description: per-source list of {last, byte}.
   logic [8:0]  mem [N][64];
   int          cnt [N];
   int          rd  [N];
   logic [10:0] exp_q [$];      // {src, last, byte}
   int          model_ptr = 0;
   int          first_valid_cyc;
   int          first_ready_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
      chk({tag, "_tx_byte"},  32'(tx_byte), 0);
      chk({tag, "_tx_last"},  32'(tx_last), 0);
      chk({tag, "_tx_src"},   32'(tx_src), 0);
      chk({tag, "_busy"},     32'(busy), 0);
      chk({tag, "_req_ready"}, 32'(req_ready), 0);
      chk({tag, "_tflag"},    32'(timeout_flag), 0);
   endtask

   task automatic clear_traffic();
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0;
         rd[i]  = 0;
      end
      exp_q.delete();
   endtask

   task automatic add_byte(input int src, input logic [7:0] b, input logic last);
      mem[src][cnt[src]] = {last, b};
      cnt[src]++;
   endtask

   // Reference: whole bursts granted round-robin among sources with pending
   // data, starting at model_ptr; pointer moves past each granted source.
   task automatic build_expected();
      int  rem [N];
      bit  more;
      for (int i = 0; i < N; i++) rem[i] = rd[i];
      do begin
         more = 1'b0;
         for (int k = 0; k < N; k++) begin
            int s;
            s = (model_ptr + k) % N;
            if (rem[s] < cnt[s]) begin
               logic [8:0] e;
               do begin
                  e = mem[s][rem[s]];
                  rem[s]++;
                  exp_q.push_back({s[SW-1:0], e});
               end while (!e[8]);
               model_ptr = (s + 1) % N;
               more = 1'b1;
               break;
            end
         end
      end while (more);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      reset_check(tag);
      req_valid = '0;
      req_last  = '0;
      req_byte  = '0;
      tx_ready  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_ptr = 0;
      clear_traffic();
   endtask

   // Drives the burst lists and checks the tx stream. Entered and left at
   // posedge+1. ready_mode 1 gives the 1,0,0 repeating tx_ready pattern.
   task automatic run_traffic(input int ready_mode, input int ready_pct, input int gap_pct,
                              input int budget, input int stop_after);
      int          cyc = 0;
      int          consumed = 0;
      logic [10:0] held = '0;
      logic        held_v = 1'b0;
      logic [10:0] got;
      logic [10:0] expv;
      logic        st;
      first_valid_cyc = -1;
      first_ready_cyc = -1;
      while ((exp_q.size() > 0) && (cyc < budget) && ((stop_after < 0) || (consumed < stop_after))) begin
         for (int i = 0; i < N; i++) begin
            if (rd[i] < cnt[i]) begin
               st = (rd[i] == 0) ? 1'b1 : mem[i][rd[i]-1][8];
               req_valid[i]        = st || ($urandom_range(99) >= gap_pct);
               req_byte[i*8 +: 8]  = mem[i][rd[i]][7:0];
               req_last[i]         = mem[i][rd[i]][8];
            end else begin
               req_valid[i]        = 1'b0;
               req_byte[i*8 +: 8]  = 8'h00;
               req_last[i]         = 1'b0;
            end
         end
         tx_ready = (ready_mode == 1) ? ((cyc % 3) == 0) : ($urandom_range(99) < ready_pct);
         #1;
         got = {tx_src, tx_last, tx_byte};
         if (held_v) chk("hold_stable", 32'(got), 32'(held));
         chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
         if (!busy) chk("ready_idle", 32'(req_ready), 0);
         if (tx_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
         if ((|req_ready) && (first_ready_cyc < 0)) first_ready_cyc = cyc;
         if (tx_valid && tx_ready) begin
            expv = exp_q.pop_front();
            chk("tx_data", 32'(got), 32'(expv));
            $display("tx src=%0d byte=%02h last=%0b", tx_src, tx_byte, tx_last);
            consumed++;
            held_v = 1'b0;
         end else begin
            held_v = tx_valid;
            held   = got;
         end
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) rd[i]++;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (stop_after < 0) begin
         chk("budget_left", 32'(exp_q.size()), 0);
         req_valid = '0;
         req_last  = '0;
         req_byte  = '0;
         tx_ready  = 1'b1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tf_cyc;
      logic r3;

      // Reset values
      do_reset("rst0");

      // Three-byte burst from requester 2, tx_ready held high
      add_byte(2, 8'hA1, 1'b0);
      add_byte(2, 8'hA2, 1'b0);
      add_byte(2, 8'hA3, 1'b1);
      build_expected();
      run_traffic(0, 100, 0, 50, -1);
      chk("t1_ready_lat", 32'(first_ready_cyc), 1);
      chk("t1_valid_lat", 32'(first_valid_cyc), 2);
      chk("t1_busy_fall", 32'(busy), 0);
      chk("t1_tx_valid_drained", 32'(tx_valid), 0);

      // Round robin from reset: 0,1,3 then 0 again after the pointer wraps
      do_reset("rst1");
      add_byte(0, 8'h10, 1'b1);
      add_byte(1, 8'h11, 1'b1);
      add_byte(3, 8'h13, 1'b1);
      build_expected();
      run_traffic(0, 100, 0, 50, -1);
      clear_traffic();
      add_byte(0, 8'h20, 1'b1);
      build_expected();
      run_traffic(0, 100, 0, 50, -1);

      // Backpressure: requester 1 four bytes, requester 0 waits its turn
      clear_traffic();
      for (int k = 0; k < 4; k++) add_byte(1, 8'(8'h40 + k), (k == 3));
      add_byte(0, 8'h50, 1'b1);
      build_expected();
      run_traffic(1, 0, 0, 100, -1);

      // Reset during byte 2 of a 5-byte burst
      clear_traffic();
      for (int k = 0; k < 5; k++) add_byte(2, 8'(8'h60 + k), (k == 4));
      build_expected();
      run_traffic(0, 100, 0, 50, 1);
      chk("t4_busy_before_rst", 32'(busy), 1);
      do_reset("rst_mid");
      add_byte(3, 8'h73, 1'b1);
      add_byte(1, 8'h71, 1'b1);
      build_expected();
      run_traffic(0, 100, 0, 50, -1);

      // Stall behaviour: requester 2 sends one byte without last then stops;
      // requester 3 is already waiting.
      do_reset("rst2");
      tf_cyc = -1;
      r3 = 1'b0;
      req_byte  = {8'h66, 8'h55, 16'h0000};
      req_last  = 4'b1000;
      req_valid = 4'b1100;
      tx_ready  = 1'b1;
`ifdef SPI_TX_STALL_TIMEOUT_EN
      for (int c = 0; c < 30; c++) begin
         if (c == 2) req_valid[2] = 1'b0;
         #1;
         if (timeout_flag && (tf_cyc < 0)) tf_cyc = c;
         if ((tf_cyc >= 0) && (c == tf_cyc + 1)) r3 = req_ready[3];
         @(posedge clk);
         #1;
      end
      chk("t5_flag_cycle", 32'(tf_cyc), 10);
      chk("t5_grant_req3", 32'(r3), 1);
`else
      for (int c = 0; c < 102; c++) begin
         if (c == 2) req_valid[2] = 1'b0;
         #1;
         if (c == 2) chk("t6_byte", 32'({tx_src, tx_byte}), 32'({2'd2, 8'h55}));
         if (c >= 2) begin
            chk("t6_busy", 32'(busy), 1);
            chk("t6_tflag", 32'(timeout_flag), 0);
         end
         @(posedge clk);
         #1;
      end
`endif

      // Randomised bursts with random gaps and backpressure
      do_reset("rst3");
      for (int r = 0; r < 4; r++) begin
         clear_traffic();
         for (int s = 0; s < N; s++) begin
            int nb;
            nb = $urandom_range(2, 0);
            for (int b = 0; b < nb; b++) begin
               int len;
               len = $urandom_range(5, 1);
               for (int k = 0; k < len; k++)
                  add_byte(s, 8'($urandom_range(255, 0)), (k == len - 1));
            end
         end
         build_expected();
         run_traffic(0, 70, 25, 2000, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
